change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 4, meaning the idle cycles between successive coin pulses (range 1..255).
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 255, meaning the maximum cycles to wait for coin_ack (used only with CHANGE_DISP_ACK_EN).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 charge_req  input  1  one-cycle request to pay out charge_amt.
REQ-006 charge_amt  input  6  amount to pay, Q1 fixed point (half-yuan units, value = yuan x 2).
REQ-007 coin_ack  input  1  dispenser mechanism acknowledge (ignored without CHANGE_DISP_ACK_EN).
REQ-008 busy  output  1  high from the cycle after an accepted request until return to IDLE.
REQ-009 coin_out  output  1  one-cycle pulse per coin ejected.
REQ-010 coin_type  output  2  denomination of the current pulse: 2'b10 = 10 yuan, 2'b01 = 1 yuan, 2'b11 = 0.5 yuan, 2'b00 = none.
REQ-011 remain  output  6  amount still to dispense, Q1.
REQ-012 done  output  1  one-cycle pulse when payout is complete.
REQ-013 fault  output  1  sticky ack-timeout flag, cleared by the next accepted request.

Function
REQ-014 States SHALL be IDLE, LOAD, SEL, PULSE, GAP, DONE.
REQ-015 In IDLE, charge_req=1 SHALL latch charge_amt into remain and move to LOAD, which asserts busy.
REQ-016 charge_req SHALL be ignored in every state other than IDLE.
REQ-017 LOAD SHALL advance to SEL unconditionally after one cycle.
REQ-018 SEL SHALL choose greedily: remain>=20 gives 10 yuan; else remain>=2 gives 1 yuan; else remain==1 gives 0.5 yuan; remain==0 goes to DONE.
REQ-019 PULSE SHALL last one cycle, drive coin_out=1 and coin_type per REQ-018, and subtract 20, 2 or 1 from remain in the same edge.
REQ-020 Without CHANGE_DISP_ACK_EN, GAP SHALL hold for exactly GAP_CYCLES cycles and then return to SEL.
REQ-021 DONE SHALL assert done for one cycle, then go to IDLE, where busy=0.
REQ-022 With charge_amt=0, the sequence SHALL be LOAD, SEL, DONE, with no coin_out pulse.
REQ-023 remain SHALL never underflow, and arithmetic SHALL stay 6-bit unsigned.
REQ-024 coin_type SHALL be 2'b00 whenever coin_out=0.

Reset
REQ-025 When rst_n=0, the block SHALL immediately force IDLE, with busy=0, coin_out=0, coin_type=0, remain=0, done=0 and fault=0.
REQ-026 Reset mid-payout SHALL abort the payout with no further pulses, and the aborted request SHALL not resume.

Configuration
REQ-027 The macro CHANGE_DISP_ACK_EN SHALL control the acknowledge handshake.
REQ-028 When CHANGE_DISP_ACK_EN is defined, GAP SHALL wait for coin_ack=1, then return to SEL on the next cycle.
REQ-029 When CHANGE_DISP_ACK_EN is defined and ACK_TIMEOUT cycles pass without coin_ack, the block SHALL set fault=1 and go to DONE, with remain keeping the undispensed amount.
REQ-030 When CHANGE_DISP_ACK_EN is not defined, coin_ack SHALL be unused and fault SHALL be tied to 0.

Structure
REQ-031 The shared package change_disp_pkg SHALL hold the state enum, the coin_type codes, and the denomination constants DEN_10=20, DEN_1=2, DEN_05=1.
REQ-032 The gap/timeout down-counter SHALL be the sub-module change_gap_timer, with a load value, a start input and an expired output, and 8-bit width.

Verification
REQ-033 charge_amt=25 -> coin_type sequence 10, 01, 01, 11, then done; remain goes 25, 5, 3, 1, 0; pulse spacing is GAP_CYCLES+2 cycles.
REQ-034 charge_amt=0 -> done two cycles after LOAD, busy high for 3 cycles, zero coin_out pulses.
REQ-035 charge_amt=63 -> three 10-yuan, one 1-yuan and one 0.5-yuan pulses, then done; remain ends at 0.
REQ-036 A second charge_req=1 with amt=10 during a payout of 40 -> ignored; exactly two 10-yuan pulses are produced.
REQ-037 rst_n low after the first pulse of amt=40 -> all outputs are 0 asynchronously, and no further pulses follow after release.
REQ-038 With CHANGE_DISP_ACK_EN, amt=4 and coin_ack never asserted -> one pulse, fault=1 after ACK_TIMEOUT cycles, done pulse, remain=2.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// rtl/change_dispenser_pkg.sv - shared states, coin codes and denominations for change_dispenser
package change_disp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEL,
    ST_PULSE,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_05   = 2'b11;

  // Amounts are Q1: half-yuan units
  localparam logic [5:0] DEN_10 = 6'd20;
  localparam logic [5:0] DEN_1  = 6'd2;
  localparam logic [5:0] DEN_05 = 6'd1;

  function automatic logic [1:0] pick_coin(input logic [5:0] amt);
    if (amt >= DEN_10)      return COIN_10;
    else if (amt >= DEN_1)  return COIN_1;
    else if (amt == DEN_05) return COIN_05;
    else                    return COIN_NONE;
  endfunction

  function automatic logic [5:0] coin_value(input logic [1:0] coin);
    case (coin)
      COIN_10: return DEN_10;
      COIN_1:  return DEN_1;
      COIN_05: return DEN_05;
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - request/payout signal bundle for change_dispenser
interface change_dispenser_if;

  logic       charge_req;
  logic [5:0] charge_amt;
  logic       coin_ack;
  logic       busy;
  logic       coin_out;
  logic [1:0] coin_type;
  logic [5:0] remain;
  logic       done;
  logic       fault;

  modport slave (
    input  charge_req, charge_amt, coin_ack,
    output busy, coin_out, coin_type, remain, done, fault
  );

  modport master (
    output charge_req, charge_amt, coin_ack,
    input  busy, coin_out, coin_type, remain, done, fault
  );

endinterface

// File: rtl/change_gap_timer.sv
// rtl/change_gap_timer.sv - 8-bit down-counter timing the inter-coin gap or ack timeout
module change_gap_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_load,
  input  logic       i_start,
  output logic       o_expired
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_start) begin
      r_count <= i_load;
    end else if (r_count != 8'd0) begin
      r_count <= r_count - 8'd1;
    end
  end

  // Loaded with N-1, so expiry falls on the N-th cycle after start
  assign o_expired = (r_count == 8'd0);

endmodule

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin payout FSM
// CHANGE_DISP_ACK_EN: wait for coin_ack after each pulse, with ACK_TIMEOUT fault
module change_dispenser
  import change_disp_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  change_dispenser_if.slave  bus
);

  state_t     r_state;
  logic [5:0] r_remain;
  logic       r_busy;
  logic       r_coin_out;
  logic [1:0] r_coin_type;
  logic       r_done;
  logic       r_fault;

  logic [1:0] w_coin;
  logic [7:0] w_timer_load;
  logic       w_timer_start;
  logic       w_expired;

  assign w_coin        = pick_coin(r_remain);
  assign w_timer_start = (r_state == ST_PULSE);

`ifdef CHANGE_DISP_ACK_EN
  assign w_timer_load = 8'(ACK_TIMEOUT - 1);
`else
  logic w_unused_ack;
  assign w_timer_load = 8'(GAP_CYCLES - 1);
  assign w_unused_ack = bus.coin_ack | (ACK_TIMEOUT == 0);
`endif

  change_gap_timer u_gap_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_timer_load),
    .i_start   (w_timer_start),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_remain    <= 6'd0;
      r_busy      <= 1'b0;
      r_coin_out  <= 1'b0;
      r_coin_type <= COIN_NONE;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_coin_out  <= 1'b0;
      r_coin_type <= COIN_NONE;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.charge_req) begin
            r_remain <= bus.charge_amt;
            r_busy   <= 1'b1;
            r_fault  <= 1'b0;
            r_state  <= ST_LOAD;
          end
        end
        ST_LOAD: r_state <= ST_SEL;
        ST_SEL: begin
          if (r_remain == 6'd0) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            // Coin chosen never exceeds remain, so this cannot underflow
            r_coin_out  <= 1'b1;
            r_coin_type <= w_coin;
            r_remain    <= r_remain - coin_value(w_coin);
            r_state     <= ST_PULSE;
          end
        end
        ST_PULSE: r_state <= ST_GAP;
        ST_GAP: begin
`ifdef CHANGE_DISP_ACK_EN
          if (bus.coin_ack) begin
            r_state <= ST_SEL;
          end else if (w_expired) begin
            r_fault <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
`else
          if (w_expired) r_state <= ST_SEL;
`endif
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.coin_out  = r_coin_out;
  assign bus.coin_type = r_coin_type;
  assign bus.remain    = r_remain;
  assign bus.done      = r_done;
`ifdef CHANGE_DISP_ACK_EN
  assign bus.fault     = r_fault;
`else
  assign bus.fault     = 1'b0;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed vector bench for change_dispenser
module tb_change_dispenser;

  localparam int GAP = 4;
  localparam int TMO = 20;
`ifdef CHANGE_DISP_ACK_EN
  localparam int SPACING = 3;
`else
  localparam int SPACING = GAP + 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  change_dispenser_if bus();

  change_dispenser #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0] amt;
    int         n;
    logic [1:0] coin[8];
    int         rem[8];
  } vec_t;

  vec_t vecs[8];

  int         p_cnt, done_cyc, done_cnt, busy_cyc, bad_type, fault_seen, timed_out;
  logic [1:0] p_type[16];
  int         p_rem[16];
  int         p_cyc[16];

  task automatic run_payout(input logic [5:0] amt, input int inject);
    @(negedge clk);
    bus.charge_req = 1'b1;
    bus.charge_amt = amt;
    p_cnt = 0; done_cyc = 0; done_cnt = 0; busy_cyc = 0;
    bad_type = 0; fault_seen = 0; timed_out = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == inject) begin
        bus.charge_req = 1'b1;
        bus.charge_amt = 6'd10;
      end else begin
        bus.charge_req = 1'b0;
      end
      if (bus.busy) busy_cyc++;
      if (bus.coin_out) begin
        if (p_cnt < 16) begin
          p_type[p_cnt] = bus.coin_type;
          p_rem[p_cnt]  = int'(bus.remain);
          p_cyc[p_cnt]  = c;
        end
        p_cnt++;
      end else if (bus.coin_type != 2'b00) begin
        bad_type++;
      end
      if (bus.fault) fault_seen = 1;
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c > 1 && !bus.busy) break;
      if (c == 400) timed_out = 1;
    end
    check("payout finished within budget", timed_out, 0);
  endtask

  task automatic check_vec(input int i, input string tag);
    check($sformatf("%s amt=%0d pulse count", tag, vecs[i].amt), p_cnt, vecs[i].n);
    for (int k = 0; k < vecs[i].n && k < p_cnt; k++) begin
      check($sformatf("%s pulse%0d coin_type", tag, k), p_type[k], vecs[i].coin[k]);
      check($sformatf("%s pulse%0d remain", tag, k), p_rem[k], vecs[i].rem[k]);
      check($sformatf("%s pulse%0d cycle", tag, k), p_cyc[k], 3 + SPACING * k);
    end
    check($sformatf("%s done cycle", tag), done_cyc, 3 + SPACING * vecs[i].n);
    check($sformatf("%s done pulse count", tag), done_cnt, 1);
    check($sformatf("%s busy cycles", tag), busy_cyc, 3 + SPACING * vecs[i].n);
    check($sformatf("%s coin_type while idle", tag), bad_type, 0);
    check($sformatf("%s fault", tag), fault_seen, 0);
    check($sformatf("%s final remain", tag), bus.remain, 0);
  endtask

  initial begin
    int cnt_out, cnt_busy, cnt_done;

    vecs[0].amt = 6'd25; vecs[0].n = 4;
    vecs[0].coin = '{2'b10, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[0].rem  = '{5, 3, 1, 0, 0, 0, 0, 0};
    vecs[1].amt = 6'd0;  vecs[1].n = 0;
    vecs[1].coin = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[1].rem  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].amt = 6'd63; vecs[2].n = 5;
    vecs[2].coin = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00};
    vecs[2].rem  = '{43, 23, 3, 1, 0, 0, 0, 0};
    vecs[3].amt = 6'd40; vecs[3].n = 2;
    vecs[3].coin = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[3].rem  = '{20, 0, 0, 0, 0, 0, 0, 0};
    vecs[4].amt = 6'd1;  vecs[4].n = 1;
    vecs[4].coin = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[4].rem  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5].amt = 6'd2;  vecs[5].n = 1;
    vecs[5].coin = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[5].rem  = '{0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6].amt = 6'd21; vecs[6].n = 2;
    vecs[6].coin = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[6].rem  = '{1, 0, 0, 0, 0, 0, 0, 0};
    vecs[7].amt = 6'd5;  vecs[7].n = 3;
    vecs[7].coin = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vecs[7].rem  = '{3, 1, 0, 0, 0, 0, 0, 0};

    bus.charge_req = 1'b0;
    bus.charge_amt = 6'd0;
`ifdef CHANGE_DISP_ACK_EN
    bus.coin_ack = 1'b1;
`else
    bus.coin_ack = 1'b0;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", bus.busy, 0);
    check("reset coin_out", bus.coin_out, 0);
    check("reset coin_type", bus.coin_type, 0);
    check("reset remain", bus.remain, 0);
    check("reset done", bus.done, 0);
    check("reset fault", bus.fault, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_payout(vecs[i].amt, 0);
      check_vec(i, $sformatf("vec%0d", i));
    end

    run_payout(6'd40, 5);
    check_vec(3, "ignored_req");

    // Reset asserted while the first 10-yuan pulse of amt=40 is on the bus
    @(negedge clk);
    bus.charge_req = 1'b1;
    bus.charge_amt = 6'd40;
    @(negedge clk);
    bus.charge_req = 1'b0;
    repeat (2) @(negedge clk);
    check("pre-reset coin_out", bus.coin_out, 1);
    check("pre-reset remain", bus.remain, 20);
    #1 rst_n = 1'b0;
    #1;
    check("async reset busy", bus.busy, 0);
    check("async reset coin_out", bus.coin_out, 0);
    check("async reset coin_type", bus.coin_type, 0);
    check("async reset remain", bus.remain, 0);
    check("async reset done", bus.done, 0);
    check("async reset fault", bus.fault, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_out = 0; cnt_busy = 0; cnt_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.coin_out) cnt_out++;
      if (bus.busy) cnt_busy++;
      if (bus.done) cnt_done++;
    end
    check("post-reset pulses", cnt_out, 0);
    check("post-reset busy cycles", cnt_busy, 0);
    check("post-reset done", cnt_done, 0);

`ifdef CHANGE_DISP_ACK_EN
    bus.coin_ack = 1'b0;
    run_payout(6'd4, 0);
    check("ack timeout pulse count", p_cnt, 1);
    check("ack timeout coin_type", p_type[0], 2'b01);
    check("ack timeout done cycle", done_cyc, 3 + 1 + TMO);
    check("ack timeout done count", done_cnt, 1);
    check("ack timeout fault seen", fault_seen, 1);
    check("ack timeout remain kept", bus.remain, 2);
    check("ack timeout fault sticky", bus.fault, 1);
    bus.coin_ack = 1'b1;
    run_payout(6'd0, 0);
    check("fault cleared by new request", fault_seen, 0);
    check("fault clear done cycle", done_cyc, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
